add_sub_seq_16b: RTL and testbench
==================================

Name: add_sub_seq_16b

Overview:
- Multi-cycle wide add/subtract sequencer that sits upstream of the 4-bit carry-lookahead add/sub slice.
- Accepts WIDTH-bit operands over a valid/ready handshake and feeds one 4-bit nibble per cycle through an internal CLA nibble adder, LSB first, chaining the carry between nibbles.
- Returns the WIDTH-bit result with carry, signed-overflow and zero flags over a second valid/ready handshake.
- Used wherever the datapath needs >4-bit arithmetic built from the existing 4-bit slice.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.
- NIBS, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, operands and ctrl valid.
- in_ready, out, 1, block can accept operands.
- a, in, WIDTH, operand A.
- b, in, WIDTH, operand B.
- ctrl, in, 1, 0 = ADD (A+B), 1 = SUB (A-B).
- out_valid, out, 1, result and flags valid.
- out_ready, in, 1, consumer takes the result.
- result, out, WIDTH, sum or difference, modulo 2^WIDTH.
- cout, out, 1, final carry out. For SUB, 1 = no borrow (A >= B unsigned).
- overflow, out, 1, two's-complement signed overflow.
- zero, out, 1, result == 0.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE and nibble index to 0.
  - result, cout, overflow, zero and out_valid are all 0; in_ready is 1.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1, latch a, ctrl and b_eff (b for ADD, ~b for SUB).
  - Carry register is loaded with ctrl (0 for ADD, 1 for SUB). Index goes to 0, state goes to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle the nibble adder takes a[4i+3:4i], b_eff[4i+3:4i] and the carry register, with no ctrl inversion inside the slice.
  - At the edge, the sum is written into result[4i+3:4i], the carry register takes the nibble carry out, and the index increments.
  - After nibble NIBS-1 is written, state goes to DONE.
- DONE:
  - out_valid = 1.
  - result, cout, overflow and zero stay stable until the edge where out_ready=1.
  - That edge returns the block to IDLE and clears out_valid. in_ready stays 0 in DONE, so there is no same-cycle re-accept.
- Latency: the accept edge is E0 and out_valid rises after edge E(NIBS), i.e. after 4 edges at WIDTH=16. Throughput is 1 operation per NIBS+2 cycles at most.
- Flags, registered at the final RUN edge:
  - cout = final carry.
  - overflow = (a[MSB] == b_eff[MSB]) && (result[MSB] != a[MSB]).
  - zero = (full result == 0).
- Subtraction is done as A + ~B + 1 across the whole width. Per-nibble negation of B is forbidden because it is incorrect for multi-nibble operands.
- While not in DONE, result may change internally. Consumers sample it only when out_valid=1.
- If in_valid drops while the block is busy, nothing happens; inputs are ignored outside IDLE.
- Reset mid-RUN or mid-DONE aborts immediately and the pending result is discarded, with out_valid=0.
- ctrl is latched at accept; later changes have no effect.

Decomposition:
- Shared package alu_pkg contains:
  - localparam NIB_W = 4.
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t.
  - typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} addsub_op_t.
- One sub-module, cla_nibble:
  - Purely combinational 4-bit carry-lookahead adder with inputs a[3:0], b[3:0], cin and outputs s[3:0], cout.
  - No internal subtraction control.
- The sequencer holds the FSM, operand and result registers, index counter and flag logic.

Test Plan:
- ADD 0x1234 + 0x0FFF -> after 4 edges out_valid=1, result=0x2233, cout=0, overflow=0, zero=0.
- ADD 0xFFFF + 0x0001 -> result=0x0000, cout=1, zero=1, overflow=0; the carry ripples through all 4 nibbles.
- ADD 0x7FFF + 0x0001 -> result=0x8000, overflow=1, cout=0. SUB 0x8000 - 0x0001 -> result=0x7FFF, overflow=1, cout=1.
- SUB 0x0005 - 0x0007 -> result=0xFFFE, cout=0 (borrow), overflow=0. SUB 0x1234 - 0x1234 -> result=0x0000, zero=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flags are stable and in_ready=0 throughout, and in_valid pulses are ignored. Then out_ready=1 for one cycle -> IDLE with in_ready=1, and the next operation is accepted.
- Reset mid-operation: assert rst_n=0 after 2 RUN edges -> outputs clear immediately (asynchronously). After release, in_ready=1 and a fresh ADD 0x0001 + 0x0001 gives 0x0002 with no stale carry.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared nibble width, sequencer states and add/sub opcode
package alu_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} addsub_op_t;
endpackage

// File: rtl/cla_nibble.sv
// cla_nibble: combinational 4-bit carry-lookahead adder, no subtract control
module cla_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign s = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/add_sub_seq_16b.sv
// add_sub_seq_16b: multi-cycle add/sub, one CLA nibble per cycle LSB first
module add_sub_seq_16b
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int NIBS = WIDTH / NIB_W;
  localparam int IW = $clog2(NIBS);
  seq_state_t state, state_n;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_r, b_r, b_eff, res_n;
  logic c_r, nc, last, accept;
  logic [NIB_W-1:0] ns;
  // subtraction is A + ~B + 1 over the full width: invert B once, seed carry with 1
  assign b_eff = (addsub_op_t'(ctrl) == OP_SUB) ? ~b : b;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_ready && in_valid;
  assign last = idx == IW'(NIBS - 1);
  cla_nibble u_nib (
    .a   (a_r[idx*NIB_W +: NIB_W]),
    .b   (b_r[idx*NIB_W +: NIB_W]),
    .cin (c_r),
    .s   (ns),
    .cout(nc)
  );
  always_comb begin
    res_n = result;
    res_n[idx*NIB_W +: NIB_W] = ns;
  end
  always_comb begin
    state_n = accept ? RUN
            : (state == RUN && last) ? DONE
            : (state == DONE && out_ready) ? IDLE
            : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      a_r <= '0;
      b_r <= '0;
      c_r <= 1'b0;
      result <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_r <= a;
        b_r <= b_eff;
        c_r <= ctrl;
        idx <= '0;
      end
      if (state == RUN) begin
        result <= res_n;
        c_r <= nc;
        idx <= idx + 1'b1;
        if (last) begin
          cout <= nc;
          overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_n[WIDTH-1] != a_r[WIDTH-1]);
          zero <= res_n == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_add_sub_seq_16b.sv
// tb_add_sub_seq_16b: directed scoreboard bench for the add/sub sequencer
module tb_add_sub_seq_16b;
  typedef struct packed {
    logic [15:0] res;
    logic c;
    logic v;
    logic z;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, ctrl, out_valid, out_ready, cout, overflow, zero;
  logic [15:0] a, b, result;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  add_sub_seq_16b #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic sub);
    logic [15:0] be;
    logic [16:0] full;
    exp_t e;
    be = sub ? ~bv : bv;
    full = {1'b0, av} + {1'b0, be} + {16'd0, sub};
    e.res = full[15:0];
    e.c = full[16];
    e.v = (av[15] == be[15]) && (full[15] != av[15]);
    e.z = full[15:0] == 16'd0;
    return e;
  endfunction
  task automatic accept(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    @(negedge clk);
    a = av;
    b = bv;
    ctrl = cv;
    in_valid = 1'b1;
    check("in_ready_at_accept", {31'd0, in_ready}, 32'd1);
    sb.push_back(model(av, bv, cv));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    ctrl = ~cv;
  endtask
  task automatic collect(input int hold);
    int n = 0;
    exp_t e, snap;
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("latency", n, 4);
    snap = '{result, cout, overflow, zero};
    repeat (hold) begin
      in_valid = 1'b1;
      a = 16'hdead;
      b = 16'hbeef;
      @(negedge clk);
      check("hold_stable", {13'd0, result, cout, overflow, zero}, {13'd0, snap});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("result", {16'd0, result}, {16'd0, e.res});
      check("cout", {31'd0, cout}, {31'd0, e.c});
      check("overflow", {31'd0, overflow}, {31'd0, e.v});
      check("zero", {31'd0, zero}, {31'd0, e.z});
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_cleared", {31'd0, out_valid}, 32'd0);
    check("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    ctrl = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_outs", {13'd0, out_valid, result, cout, overflow, zero}, 32'd0);
    rst_n = 1'b1;
    accept(16'h1234, 16'h0FFF, 1'b0);
    collect(0);
    accept(16'hFFFF, 16'h0001, 1'b0);
    collect(0);
    accept(16'h7FFF, 16'h0001, 1'b0);
    collect(0);
    accept(16'h8000, 16'h0001, 1'b1);
    collect(0);
    accept(16'h0005, 16'h0007, 1'b1);
    collect(0);
    accept(16'h1234, 16'h1234, 1'b1);
    collect(5);
    accept(16'h00F0, 16'h0F10, 1'b0);
    collect(0);
    for (int i = 0; i < 6; i++) begin
      accept(16'($urandom), 16'($urandom), 1'($urandom));
      collect(i % 3);
    end
    accept(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_outs", {13'd0, result, cout, overflow, zero}, 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    accept(16'h0001, 16'h0001, 1'b0);
    collect(0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
